rr_push_arbiter: RTL and testbench
==================================

Name: rr_push_arbiter

Overview:
Round-robin, packet-locked arbiter that shares the single push port of a fifo_sr (HEADS=1) or cdc_fifo_sr between REQS requesters. A grant is held for a whole multi-beat packet, which is delimited by req_last. Flow control toward the FIFO is a local credit counter: it starts at DEPTH, is spent on each push, and is returned one per consumer pop. The FIFO is therefore never pushed while full, and the one-cycle lag of src_num_avail does not matter.

Parameters:
REQS, 4, number of requesters; must be >= 2.
WIDTH, 32, data width of each requester and of the FIFO input.
DEPTH, 8, FIFO depth and initial credit count; must be a power of 2.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  REQS  per-requester beat valid.
req_data  in  REQS x WIDTH  per-requester beat data, packed [REQS-1:0][WIDTH-1:0].
req_last  in  REQS  marks the final beat of the packet.
req_ready  out  REQS  beat accepted when valid & ready; one-hot or zero.
fifo_push  out  1  drives the FIFO push input.
fifo_dinp  out  WIDTH  drives the FIFO data input.
credit_ret  in  1  one FIFO entry freed this cycle (consumer pop accepted).
credits  out  $clog2(DEPTH)+1  current credit count, 0..DEPTH.
grant_id  out  $clog2(REQS)  requester currently holding the grant.
busy  out  1  high when state is LOCKED.
credit_err  out  1  sticky flag: credit_ret received while credits==DEPTH.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, credits=DEPTH, credit_err=0, busy=0. Hence req_ready=0, fifo_push=0 and fifo_dinp=0 during and after reset.
- Reset is async and may assert mid-packet: the partial packet is abandoned, and the FIFO contents are the owner's responsibility.
- FSM states: IDLE and LOCKED.
- IDLE arbitration:
  - Search requesters rr_ptr, rr_ptr+1, ... modulo REQS.
  - The first one with req_valid=1 wins; at the clock edge grant_id is set to the winner and state moves to LOCKED.
  - If no requester is valid, stay in IDLE.
  - req_ready is 0 in IDLE, so arbitration costs one cycle per packet.
- LOCKED:
  - req_ready[grant_id] = (credits != 0); all other req_ready bits are 0.
  - fifo_push = req_valid[grant_id] & req_ready[grant_id].
  - fifo_dinp = req_data[grant_id] when fifo_push=1, otherwise 0.
  - All three outputs are combinational from registered state plus inputs.
- Packet end: a beat accepted with req_last[grant_id]=1 sets rr_ptr to (grant_id+1) mod REQS and returns state to IDLE on the next edge.
- A requester dropping req_valid mid-packet keeps the lock; no timeout.
- Credits:
  - Next value = credits - fifo_push + credit_ret.
  - Push and return in the same cycle leave the count unchanged.
  - Pushing is gated on the registered credits, so a return arriving while credits==0 only enables pushing from the next cycle.
  - A return while credits==DEPTH and no push saturates at DEPTH and sets credit_err, which stays set until reset.
- Arithmetic: credits uses width $clog2(DEPTH)+1; rr_ptr and grant_id wrap modulo REQS. When REQS is not a power of 2, the wrap is an explicit compare to REQS-1, not truncation.
- Fairness: after a packet from requester k, requester k has lowest priority at the next arbitration. Any continuously valid requester is granted within REQS-1 packets.
- Latency: first-beat valid in IDLE gives ready 1 cycle later, given credits. Within a packet, throughput is 1 beat/cycle while credits > 0.

Test Plan:
1. Reset, then REQS=4 with req_valid=4'b0001, packet of 3 beats (last on beat 3), no credit_ret -> grant_id=0 one cycle after valid. Beats arrive on 3 consecutive cycles with fifo_push=1. credits goes 8→5, then IDLE, rr_ptr=1.
2. All 4 requesters continuously valid with 1-beat packets and credit_ret tied to fifo_push -> grants in order 0,1,2,3,0. Each grant is separated by one IDLE cycle; credits stays 8.
3. Single requester, 10-beat packet, no credit_ret -> exactly 8 beats are pushed and credits=0. req_ready=0 for the stall. One credit_ret pulse -> credits=1, the 9th beat is pushed the following cycle, credits back to 0.
4. credits=3 with fifo_push and credit_ret both high for 4 cycles -> credits stays 3 and no stall.
5. credits=8 and idle, credit_ret=1 for 1 cycle -> credits remains 8 and credit_err=1, still 1 after 5 further cycles.
6. rst asserted mid-packet, asynchronously between clock edges, with grant_id=2 -> req_ready, fifo_push and busy drop to 0 immediately. After release: credits=8, rr_ptr=0, and requester 0 wins if valid alongside requester 2.

Source files
------------

// File: rtl/rr_push_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO push port among REQS requesters.
// A grant is held until the beat marked req_last; a local credit counter guards FIFO space.
module rr_push_arbiter #(
  parameter int REQS  = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int IW = $clog2(REQS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQS-1:0]             req_valid,
  input  logic [REQS-1:0][WIDTH-1:0]  req_data,
  input  logic [REQS-1:0]             req_last,
  output logic [REQS-1:0]             req_ready,
  output logic                        fifo_push,
  output logic [WIDTH-1:0]            fifo_dinp,
  input  logic                        credit_ret,
  output logic [CW-1:0]               credits,
  output logic [IW-1:0]               grant_id,
  output logic                        busy,
  output logic                        credit_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Handshake: a beat moves when req_valid[i] & req_ready[i]; ready never
  // depends on valid, and only the granted requester can see ready.

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            credit_err_q, credit_err_d;

  logic            found;
  logic [IW-1:0]   winner;
  logic [IW:0]     idx;
  logic            can_push;
  logic            beat_last;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < REQS; i++) begin
      // explicit wrap so non-power-of-2 REQS never aliases onto a missing requester
      idx = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (idx > (IW+1)'(REQS-1)) idx = idx - (IW+1)'(REQS);
      if (!found && req_valid[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    can_push  = (state_q == LOCKED) && (credits_q != '0);
    req_ready = '0;
    for (int i = 0; i < REQS; i++) begin
      req_ready[i] = can_push && (grant_id_q == IW'(i));
    end
    fifo_push = can_push && req_valid[grant_id_q];
    fifo_dinp = fifo_push ? req_data[grant_id_q] : '0;
    beat_last = fifo_push && req_last[grant_id_q];
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = winner;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (beat_last) begin
          rr_ptr_d = (grant_id_q == IW'(REQS-1)) ? '0 : grant_id_q + IW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_push && !credit_ret) begin
      credits_d = credits_q - CW'(1);
    end else if (!fifo_push && credit_ret) begin
      if (credits_q == CW'(DEPTH)) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      credits_q    <= CW'(DEPTH);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign credits    = credits_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == LOCKED);
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_rr_push_arbiter.sv
// Directed testbench for rr_push_arbiter (REQS=4, WIDTH=32, DEPTH=8).
// Linear sequence of steps with immediate assertions at each check point.
module tb_rr_push_arbiter;

  localparam int REQS  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic                       clk;
  logic                       rst;
  logic [REQS-1:0]            req_valid;
  logic [REQS-1:0][WIDTH-1:0] req_data;
  logic [REQS-1:0]            req_last;
  logic [REQS-1:0]            req_ready;
  logic                       fifo_push;
  logic [WIDTH-1:0]           fifo_dinp;
  logic                       credit_ret;
  logic                       credit_ret_drv;
  logic                       tie_ret;
  logic [3:0]                 credits;
  logic [1:0]                 grant_id;
  logic                       busy;
  logic                       credit_err;

  int n_checks = 0;
  int n_fails  = 0;

  // credit_ret can be looped back from fifo_push to model an always-draining consumer
  assign credit_ret = tie_ret ? fifo_push : credit_ret_drv;

  rr_push_arbiter #(.REQS(REQS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_push  (fifo_push),
    .fifo_dinp  (fifo_dinp),
    .credit_ret (credit_ret),
    .credits    (credits),
    .grant_id   (grant_id),
    .busy       (busy),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid      = '0;
    req_last       = '0;
    req_data       = '0;
    credit_ret_drv = 1'b0;
    tie_ret        = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_push", 64'(fifo_push), 64'(0));
    check("rst_dinp", 64'(fifo_dinp), 64'(0));
    check("rst_credits", 64'(credits), 64'(8));
    check("rst_grant", 64'(grant_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(credit_err), 64'(0));
    apply_reset();

    // 1: three-beat packet from requester 0, then rr_ptr must favour requester 1
    req_valid   = 4'b0001;
    req_data[0] = 32'hA000_0000;
    #1;
    check("t1_idle_busy", 64'(busy), 64'(0));
    check("t1_idle_ready", 64'(req_ready), 64'(0));
    check("t1_idle_push", 64'(fifo_push), 64'(0));
    step();
    for (int b = 0; b < 3; b++) begin
      req_data[0] = 32'hA000_0000 + 32'(b);
      req_last[0] = (b == 2);
      #1;
      check("t1_grant", 64'(grant_id), 64'(0));
      check("t1_ready", 64'(req_ready), 64'(4'b0001));
      check("t1_push", 64'(fifo_push), 64'(1));
      check("t1_dinp", 64'(fifo_dinp), 64'(32'hA000_0000 + 32'(b)));
      check("t1_credits", 64'(credits), 64'(8 - b));
      step();
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    check("t1_end_busy", 64'(busy), 64'(0));
    check("t1_end_credits", 64'(credits), 64'(5));
    req_valid   = 4'b0011;
    req_last    = 4'b0011;
    req_data[0] = 32'hB000_0000;
    req_data[1] = 32'hB000_0001;
    step();
    check("t1_rr_grant", 64'(grant_id), 64'(1));
    check("t1_rr_dinp", 64'(fifo_dinp), 64'(32'hB000_0001));
    step();
    check("t1_rr_credits", 64'(credits), 64'(4));
    apply_reset();

    // 2: all requesters valid, single-beat packets, credits looped back
    tie_ret   = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < REQS; i++) req_data[i] = 32'hC000_0000 + 32'(i);
    #1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_busy", 64'(busy), 64'(1));
      check("t2_grant", 64'(grant_id), 64'(k % 4));
      check("t2_dinp", 64'(fifo_dinp), 64'(32'hC000_0000 + 32'(k % 4)));
      check("t2_credits", 64'(credits), 64'(8));
      step();
      check("t2_gap_busy", 64'(busy), 64'(0));
      check("t2_gap_push", 64'(fifo_push), 64'(0));
    end
    check("t2_final_credits", 64'(credits), 64'(8));
    apply_reset();

    // 3: ten-beat packet with no returns stalls after eight beats
    req_valid = 4'b0001;
    #1;
    step();
    for (int b = 0; b < 8; b++) begin
      req_data[0] = 32'hD000_0000 + 32'(b);
      #1;
      check("t3_push", 64'(fifo_push), 64'(1));
      check("t3_credits", 64'(credits), 64'(8 - b));
      step();
    end
    req_data[0] = 32'hD000_0008;
    #1;
    check("t3_stall_ready", 64'(req_ready), 64'(0));
    check("t3_stall_push", 64'(fifo_push), 64'(0));
    check("t3_stall_dinp", 64'(fifo_dinp), 64'(0));
    check("t3_credits0", 64'(credits), 64'(0));
    step();
    check("t3_stall2_ready", 64'(req_ready), 64'(0));
    credit_ret_drv = 1'b1;
    #1;
    check("t3_ret_gated", 64'(fifo_push), 64'(0));
    step();
    credit_ret_drv = 1'b0;
    #1;
    check("t3_credits1", 64'(credits), 64'(1));
    check("t3_ready9", 64'(req_ready), 64'(4'b0001));
    check("t3_push9", 64'(fifo_push), 64'(1));
    check("t3_dinp9", 64'(fifo_dinp), 64'(32'hD000_0008));
    step();
    check("t3_credits_back0", 64'(credits), 64'(0));
    check("t3_push10", 64'(fifo_push), 64'(0));
    apply_reset();

    // 4: push and return together at credits=3 keep the count steady
    req_valid = 4'b0001;
    #1;
    step();
    for (int b = 0; b < 5; b++) step();
    check("t4_credits3", 64'(credits), 64'(3));
    credit_ret_drv = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t4_push", 64'(fifo_push), 64'(1));
      check("t4_credits", 64'(credits), 64'(3));
      step();
    end
    credit_ret_drv = 1'b0;
    #1;
    check("t4_credits_end", 64'(credits), 64'(3));
    apply_reset();

    // 5: spurious return at full credits saturates and sets the sticky error
    credit_ret_drv = 1'b1;
    #1;
    check("t5_err_before", 64'(credit_err), 64'(0));
    step();
    credit_ret_drv = 1'b0;
    #1;
    check("t5_credits", 64'(credits), 64'(8));
    check("t5_err", 64'(credit_err), 64'(1));
    for (int c = 0; c < 5; c++) step();
    check("t5_err_sticky", 64'(credit_err), 64'(1));
    check("t5_credits_sticky", 64'(credits), 64'(8));
    apply_reset();
    check("t5_err_cleared", 64'(credit_err), 64'(0));

    // 6: asynchronous reset in the middle of requester 2's packet
    req_valid   = 4'b0100;
    req_data[0] = 32'hE000_0000;
    req_data[2] = 32'hE000_0002;
    #1;
    step();
    check("t6_grant2", 64'(grant_id), 64'(2));
    check("t6_push", 64'(fifo_push), 64'(1));
    step();
    check("t6_credits7", 64'(credits), 64'(7));
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 64'(req_ready), 64'(0));
    check("t6_rst_push", 64'(fifo_push), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_credits", 64'(credits), 64'(8));
    req_valid = 4'b0101;
    #1;
    rst = 1'b0;
    step();
    check("t6_winner0", 64'(grant_id), 64'(0));
    check("t6_busy", 64'(busy), 64'(1));
    check("t6_dinp", 64'(fifo_dinp), 64'(32'hE000_0000));
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
